// File: rtl/dh_recip_cal_if.sv
// dh_recip_cal_if: strobe/result bundle between the channel-norm stage,
// the D_h reciprocal unit and the equalizer-scaling stage.
interface dh_recip_cal_if #(
  parameter int N = 16
);
  logic [N-1:0] dh_in;
  logic         dh_valid;
  logic         clr_flags;
  logic [N-1:0] inv_dh;
  logic         inv_valid;
  logic         busy;
  logic         div0;
  logic         sign_err;
  logic         overrun;

  // Norm stage / controller side: supplies D_h, consumes the reciprocal.
  modport master (
    output dh_in, dh_valid, clr_flags,
    input  inv_dh, inv_valid, busy, div0, sign_err, overrun
  );

  // Reciprocal unit side.
  modport slave (
    input  dh_in, dh_valid, clr_flags,
    output inv_dh, inv_valid, busy, div0, sign_err, overrun
  );
endinterface

// File: rtl/dh_recip_cal.sv
// dh_recip_cal: bit-serial restoring reciprocal 1/D_h for the SOML decoder.
// D_h and 1/D_h are sign-magnitude Q(N-Q).Q words; the result sign is always 0.
// A one-entry buffer holds a D_h that arrives while a division is in flight.
// Optional feature macro: DH_RECIP_ROUND_EN (one extra quotient bit, then
// round-half-up shift back to Q fractional bits; one extra cycle of latency).
module dh_recip_cal #(
  parameter int N = 16,
  parameter int Q = 8
) (
  input logic           clk,
  input logic           rst,
  dh_recip_cal_if.slave bus
);

`ifdef DH_RECIP_ROUND_EN
  localparam int K = 2 * Q + 2;   // iterations; dividend is 2^(2Q+1)
`else
  localparam int K = 2 * Q + 1;   // iterations; dividend is 2^(2Q)
`endif
  localparam int MW    = N - 1;                 // magnitude width
  localparam int CW    = (K > N) ? K : N;       // width for the saturation compare
  localparam int CNT_W = $clog2(K + 1);

  localparam logic [CW-1:0]    SAT_CW   = {{(CW - MW){1'b0}}, {MW{1'b1}}};
  localparam logic [N-1:0]     SAT_N    = {1'b0, {MW{1'b1}}};
  localparam logic [K-1:0]     DVD_INIT = {1'b1, {(K - 1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Control and datapath registers
  state_t           r_state;
  logic [MW-1:0]    r_div;        // divisor magnitude
  logic             r_zero;       // divisor magnitude is zero
  logic [MW-1:0]    r_rem;        // partial remainder, always < divisor
  logic [K-1:0]     r_quo;        // quotient, built LSB-in
  logic [K-1:0]     r_dvd;        // dividend, shifted out MSB first
  logic [CNT_W-1:0] r_cnt;        // iteration counter

  // Input buffer
  logic [N-1:0]     r_buf;
  logic             r_buf_full;

  // Registered outputs
  logic [N-1:0]     r_inv_dh;
  logic             r_inv_valid;
  logic             r_busy;
  logic             r_div0;
  logic             r_sign_err;
  logic             r_overrun;

  // Combinational helpers
  logic [N-1:0]     w_rem_sh;
  logic             w_ge;
  logic [MW-1:0]    w_rem_nx;
  logic [K-1:0]     w_quo_nx;
  logic [CW-1:0]    w_res;
  logic             w_sat;
  logic [N-1:0]     w_inv;
  logic             w_load;
  logic [N-1:0]     w_load_word;
  logic             w_set_div0;
  logic             w_set_sign;
  logic             w_set_ovr;

  // One restoring step: bring in the next dividend bit, trial-subtract.
  // The shifted remainder is < 2*divisor, so it needs one bit more than r_rem,
  // while the post-subtract remainder fits back into MW bits.
  assign w_rem_sh = {r_rem, r_dvd[K-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx = w_ge ? (w_rem_sh[MW-1:0] - r_div) : w_rem_sh[MW-1:0];
  assign w_quo_nx = {r_quo[K-2:0], w_ge};

  // Final quotient scaling: plain truncation, or drop the extra bit with round-half-up.
  // NOTE: every variable written here is assigned on every path, so no latch is inferred.
  always_comb begin
`ifdef DH_RECIP_ROUND_EN
    w_res = CW'(r_quo >> 1) + CW'(r_quo[0]);
`else
    w_res = CW'(r_quo);
`endif
  end

  // Saturate to the largest positive magnitude on a zero or too-small divisor.
  assign w_sat = r_zero || (w_res > SAT_CW);
  assign w_inv = w_sat ? SAT_N : w_res[N-1:0];

  // A new division starts from IDLE; a waiting buffered value has priority.
  assign w_load      = (r_state == S_IDLE) && (r_buf_full || bus.dh_valid);
  assign w_load_word = r_buf_full ? r_buf : bus.dh_in;

  assign w_set_div0 = (r_state == S_FIN) && w_sat;
  assign w_set_sign = w_load && w_load_word[N-1];
  assign w_set_ovr  = (r_state != S_IDLE) && bus.dh_valid && r_buf_full;

  // Controller FSM and divider datapath with registered result outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_zero      <= 1'b0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvd       <= '0;
      r_cnt       <= '0;
      r_inv_dh    <= '0;
      r_inv_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_inv_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_load) begin
            r_div   <= w_load_word[MW-1:0];
            r_zero  <= (w_load_word[MW-1:0] == '0);
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvd   <= DVD_INIT;
            r_cnt   <= '0;
            r_state <= S_DIV;
            r_busy  <= 1'b1;
          end
        end
        S_DIV: begin
          if (r_zero) begin
            // Zero divisor: no iterations, result is forced in FIN.
            r_state <= S_FIN;
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_dvd <= r_dvd << 1;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_LAST) begin
              r_state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          r_inv_dh    <= w_inv;
          r_inv_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Input buffer capture/drain and sticky status flags (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_div0     <= 1'b0;
      r_sign_err <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        if (r_buf_full) begin
          // Buffer drains into the divider; a coincident strobe refills it.
          r_buf_full <= bus.dh_valid;
          if (bus.dh_valid) begin
            r_buf <= bus.dh_in;
          end
        end
      end else if (bus.dh_valid && !r_buf_full) begin
        r_buf      <= bus.dh_in;
        r_buf_full <= 1'b1;
      end

      r_div0     <= w_set_div0 || (r_div0     && !bus.clr_flags);
      r_sign_err <= w_set_sign || (r_sign_err && !bus.clr_flags);
      r_overrun  <= w_set_ovr  || (r_overrun  && !bus.clr_flags);
    end
  end

  assign bus.inv_dh    = r_inv_dh;
  assign bus.inv_valid = r_inv_valid;
  assign bus.busy      = r_busy;
  assign bus.div0      = r_div0;
  assign bus.sign_err  = r_sign_err;
  assign bus.overrun   = r_overrun;

endmodule
